scan_controller: RTL and testbench
==================================

Name: scan_controller

Overview:
- Sequences the solar-tracker search: raster-sweeps the H and V servo pulse widths over a grid and waits for servo settling at each point.
- Requests one ADC sample per point and pulses CAPTURE into the max-voltage register whenever the sample beats the stored maximum.
- At sweep end, parks both servos at the stored max position.
- Sits between the ADC front end, the max register and the two PWM generators.

Parameters:
- PW_MIN, 500, minimum pulse width (PWM ticks), sweep start and reset position
- PW_MAX, 2500, maximum pulse width; no grid point exceeds it
- PW_STEP, 100, grid increment on both axes (must be >0)
- SETTLE_CYCLES, 2000000, CLK cycles waited after each move before sampling (must be >=1)
- ADC_W, 12, ADC sample width

Ports:
- CLK  in  1  system clock
- RST_N  in  1  asynchronous active-low reset
- START  in  1  one-cycle request to begin a sweep; ignored while BUSY
- ABORT  in  1  abandon sweep, return to IDLE
- ADC_DATA  in  ADC_W  raw ADC sample
- ADC_VALID  in  1  ADC_DATA valid this cycle
- LV  in  ADC_W  current stored max value from max register
- pulseWidth_max_H  in  32  stored best H position
- pulseWidth_max_V  in  32  stored best V position
- ADC_REQ  out  1  one-cycle sample request
- CAPTURE  out  1  one-cycle load strobe to max register (its GT)
- MAX_CLR  out  1  one-cycle clear strobe to max register (its RST)
- pulseWidth_H  out  32  commanded H pulse width
- pulseWidth_V  out  32  commanded V pulse width
- BUSY  out  1  sweep in progress
- DONE  out  1  one-cycle pulse on sweep completion

Behaviour:
- Reset (RST_N=0, async): state IDLE; pulseWidth_H=pulseWidth_V=PW_MIN; ADC_REQ, CAPTURE, MAX_CLR, BUSY and DONE = 0; settle counter = 0. All outputs are registered.
- States: IDLE, CLEAR, SETTLE, REQ, WAIT, STEP, PARK.
- IDLE: outputs hold the last position. START=1 -> CLEAR.
- CLEAR: MAX_CLR=1 for exactly one cycle; H=V=PW_MIN; BUSY=1 from this cycle until DONE -> SETTLE.
- SETTLE: counter counts SETTLE_CYCLES cycles -> REQ.
- REQ: ADC_REQ=1 for one cycle -> WAIT.
- WAIT: hold until ADC_VALID=1.
  - If ADC_DATA > LV (unsigned, strict), CAPTURE=1 on the next cycle while pulseWidth_H/V remain unchanged.
  - Equal values never capture.
  - -> STEP.
  - ADC_VALID outside WAIT is ignored.
- STEP (one cycle, H inner axis, V outer):
  - If H+PW_STEP <= PW_MAX: H += PW_STEP, -> SETTLE.
  - Else if V+PW_STEP <= PW_MAX: H = PW_MIN, V += PW_STEP, -> SETTLE.
  - Else -> PARK.
  - Comparisons are done in 33 bits, so no wrap.
- CAPTURE is asserted in the STEP cycle; the register updates on the edge ending it. The position change is visible from the following cycle.
- PARK:
  - Entered no earlier than one cycle after the final CAPTURE, so the max inputs are settled.
  - Load pulseWidth_H/V from pulseWidth_max_H/V, DONE=1 for one cycle, BUSY=0 -> IDLE.
- Grid points per axis = floor((PW_MAX-PW_MIN)/PW_STEP)+1.
- ABORT (any non-IDLE state, priority over all else): next cycle IDLE, BUSY=0, no DONE, no CAPTURE. Position holds; the max register keeps its partial contents.
- START with ABORT in IDLE: ABORT wins, stay IDLE.
- START while BUSY: ignored.
- Reset mid-sweep: immediate return to reset values. The max register is not cleared by this block (MAX_CLR=0).

Decomposition:
- Shared package holds:
  - state encoding constants
  - PW_MIN/PW_MAX/PW_STEP defaults, shared with the PWM generators and the max register reset value (500)
- One sub-module: settle_timer (load/count/expire, width from SETTLE_CYCLES). The FSM and axis stepping stay in scan_controller.

Test Plan:
1. Params PW_MIN=500, PW_MAX=700, PW_STEP=100, SETTLE_CYCLES=4; START; ADC returns increasing 1..9 -> 9 ADC_REQs in order (H,V) = (500,500),(600,500),(700,500),(500,600)..(700,700); 9 CAPTUREs; final position = (700,700); DONE pulse; BUSY low after.
2. Same grid; ADC returns 100 everywhere except 900 at (600,700), with the max register modelled -> exactly 2 CAPTUREs; park at (600,700).
3. Equal peak: 800 returned at (500,500) and at (700,600) -> second point not captured; park at (500,500).
4. ABORT during the 3rd SETTLE -> IDLE next cycle; BUSY=0; no DONE; outputs stay (700,500); new START issues MAX_CLR and restarts at (500,500).
5. Assert RST_N=0 mid-WAIT, asynchronously off a clock edge -> outputs at reset values immediately: position (500,500), all strobes 0.
6. START pulses while BUSY, and ADC_VALID pulses during SETTLE -> no effect on sequence, REQ count or CAPTURE count.

Source files
------------

// File: rtl/scan_controller_pkg.sv
// Shared definitions for the solar-tracker scan controller: state encoding,
// default grid geometry and a small helper for overflow-safe axis stepping.
package scan_controller_pkg;

    // Grid defaults, shared with the PWM generators and the max register
    // (whose position reset value is PW_MIN_DEF).
    localparam int unsigned PW_MIN_DEF        = 500;
    localparam int unsigned PW_MAX_DEF        = 2500;
    localparam int unsigned PW_STEP_DEF       = 100;
    localparam int unsigned SETTLE_CYCLES_DEF = 2000000;
    localparam int unsigned ADC_W_DEF         = 12;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_SETTLE = 3'd2,
        S_REQ    = 3'd3,
        S_WAIT   = 3'd4,
        S_STEP   = 3'd5,
        S_PARK   = 3'd6
    } state_t;

    // True when pos + step stays within limit; evaluated in 33 bits so a
    // position near 2^32 cannot wrap around and look small.
    function automatic logic step_fits(input logic [31:0] pos,
                                       input int unsigned step,
                                       input int unsigned limit);
        logic [32:0] w_sum;
        w_sum = {1'b0, pos} + 33'(step);
        return (w_sum <= 33'(limit));
    endfunction

endpackage

// File: rtl/scan_controller_if.sv
// Bus between the scan controller and its neighbours: ADC front end,
// max-voltage register and the two servo PWM generators.
interface scan_controller_if
    import scan_controller_pkg::*;
#(
    parameter int unsigned ADC_W = ADC_W_DEF
);
    logic             START;
    logic             ABORT;
    logic [ADC_W-1:0] ADC_DATA;
    logic             ADC_VALID;
    logic [ADC_W-1:0] LV;
    logic [31:0]      pulseWidth_max_H;
    logic [31:0]      pulseWidth_max_V;
    logic             ADC_REQ;
    logic             CAPTURE;
    logic             MAX_CLR;
    logic [31:0]      pulseWidth_H;
    logic [31:0]      pulseWidth_V;
    logic             BUSY;
    logic             DONE;

    // Controller side
    modport master (
        input  START, ABORT, ADC_DATA, ADC_VALID, LV,
               pulseWidth_max_H, pulseWidth_max_V,
        output ADC_REQ, CAPTURE, MAX_CLR, pulseWidth_H, pulseWidth_V,
               BUSY, DONE
    );

    // Peripheral side (ADC, max register, PWM generators, host)
    modport slave (
        output START, ABORT, ADC_DATA, ADC_VALID, LV,
               pulseWidth_max_H, pulseWidth_max_V,
        input  ADC_REQ, CAPTURE, MAX_CLR, pulseWidth_H, pulseWidth_V,
               BUSY, DONE
    );
endinterface

// File: rtl/scan_controller_settle_timer.sv
// Servo settling timer: load arms it for CYCLES cycles of counting,
// o_expired is high in the last of those cycles and stays high until reloaded.
module scan_controller_settle_timer #(
    parameter int unsigned CYCLES = 4
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic i_load,
    input  logic i_en,
    output logic o_expired
);
    localparam int unsigned     CNT_W    = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(CYCLES - 1);

    logic [CNT_W-1:0] r_count;

    // Down-counter: load has priority, then count while enabled until zero
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= LOAD_VAL;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_expired = (r_count == '0);

endmodule

// File: rtl/scan_controller.sv
// Solar-tracker raster search: sweeps H (inner) and V (outer) servo pulse
// widths over a grid, samples the ADC at each settled point, strobes the max
// register on a new maximum and finally parks at the best position found.
module scan_controller
    import scan_controller_pkg::*;
#(
    parameter int unsigned PW_MIN        = PW_MIN_DEF,
    parameter int unsigned PW_MAX        = PW_MAX_DEF,
    parameter int unsigned PW_STEP       = PW_STEP_DEF,
    parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF,
    parameter int unsigned ADC_W         = ADC_W_DEF
) (
    input  logic              CLK,
    input  logic              RST_N,
    scan_controller_if.master bus
);
    localparam logic [31:0] PW_MIN_L  = 32'(PW_MIN);
    localparam logic [31:0] PW_STEP_L = 32'(PW_STEP);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [31:0]      r_pw_h;
    logic [31:0]      r_pw_v;
    logic [31:0]      w_pw_h_nxt;
    logic [31:0]      w_pw_v_nxt;
    logic             r_adc_req;
    logic             r_capture;
    logic             r_max_clr;
    logic             r_busy;
    logic             r_done;
    logic             w_capture_nxt;
    logic             w_done_nxt;
    logic             w_timer_load;
    logic             w_timer_expired;
    logic             w_h_fits;
    logic             w_v_fits;
    logic [ADC_W-1:0] w_sample;
    logic [ADC_W-1:0] w_level;

    assign w_sample = bus.ADC_DATA;
    assign w_level  = bus.LV;
    assign w_h_fits = step_fits(r_pw_h, PW_STEP, PW_MAX);
    assign w_v_fits = step_fits(r_pw_v, PW_STEP, PW_MAX);

    // Re-arm the settle timer on every entry into SETTLE
    assign w_timer_load = (w_state_nxt == S_SETTLE) && (r_state != S_SETTLE);

    scan_controller_settle_timer #(
        .CYCLES (SETTLE_CYCLES)
    ) u_settle_timer (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .i_load    (w_timer_load),
        .i_en      (r_state == S_SETTLE),
        .o_expired (w_timer_expired)
    );

    // Next-state, next-position and next-strobe decode
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // can leave a value unassigned and infer a latch.
        w_state_nxt   = r_state;
        w_pw_h_nxt    = r_pw_h;
        w_pw_v_nxt    = r_pw_v;
        w_capture_nxt = 1'b0;
        w_done_nxt    = 1'b0;

        if (bus.ABORT) begin
            // Abort wins everywhere: drop to IDLE, keep position, no strobes.
            // In IDLE this also suppresses a coincident START.
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.START) begin
                        w_state_nxt = S_CLEAR;
                        w_pw_h_nxt  = PW_MIN_L;
                        w_pw_v_nxt  = PW_MIN_L;
                    end
                end
                S_CLEAR: w_state_nxt = S_SETTLE;
                S_SETTLE: begin
                    if (w_timer_expired) begin
                        w_state_nxt = S_REQ;
                    end
                end
                S_REQ: w_state_nxt = S_WAIT;
                S_WAIT: begin
                    if (bus.ADC_VALID) begin
                        w_state_nxt   = S_STEP;
                        // Strictly greater: an equal sample never moves the max
                        w_capture_nxt = (w_sample > w_level);
                    end
                end
                S_STEP: begin
                    // CAPTURE is high this cycle, so the position must not
                    // change until the edge that ends it.
                    if (w_h_fits) begin
                        w_pw_h_nxt  = r_pw_h + PW_STEP_L;
                        w_state_nxt = S_SETTLE;
                    end else if (w_v_fits) begin
                        w_pw_h_nxt  = PW_MIN_L;
                        w_pw_v_nxt  = r_pw_v + PW_STEP_L;
                        w_state_nxt = S_SETTLE;
                    end else begin
                        w_state_nxt = S_PARK;
                    end
                end
                S_PARK: begin
                    // One cycle after the last CAPTURE, so the max register
                    // outputs already hold the final best position.
                    w_pw_h_nxt  = bus.pulseWidth_max_H;
                    w_pw_v_nxt  = bus.pulseWidth_max_V;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // State, position and registered strobes
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state   <= S_IDLE;
            r_pw_h    <= PW_MIN_L;
            r_pw_v    <= PW_MIN_L;
            r_adc_req <= 1'b0;
            r_capture <= 1'b0;
            r_max_clr <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            r_state   <= w_state_nxt;
            r_pw_h    <= w_pw_h_nxt;
            r_pw_v    <= w_pw_v_nxt;
            r_adc_req <= (w_state_nxt == S_REQ);
            r_capture <= w_capture_nxt;
            r_max_clr <= (w_state_nxt == S_CLEAR);
            r_busy    <= (w_state_nxt != S_IDLE);
            r_done    <= w_done_nxt;
        end
    end

    assign bus.ADC_REQ      = r_adc_req;
    assign bus.CAPTURE      = r_capture;
    assign bus.MAX_CLR      = r_max_clr;
    assign bus.pulseWidth_H = r_pw_h;
    assign bus.pulseWidth_V = r_pw_v;
    assign bus.BUSY         = r_busy;
    assign bus.DONE         = r_done;

endmodule

// File: tb/tb_scan_controller.sv
// Scoreboard bench for scan_controller on a 3x3 grid (500..700 step 100,
// settle 4 cycles). Stimulus pushes expected REQ/CAPTURE/DONE positions;
// a negedge monitor pops and compares them as the DUT strobes.
module tb_scan_controller;

    logic clk;
    logic rst_n;

    scan_controller_if #(.ADC_W(12)) bus ();

    scan_controller #(
        .PW_MIN        (500),
        .PW_MAX        (700),
        .PW_STEP       (100),
        .SETTLE_CYCLES (4),
        .ADC_W         (12)
    ) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Positions are encoded as H*10000+V for readable messages
    int exp_req[$];
    int exp_cap[$];
    int exp_done[$];
    int exp_clr = 0;

    // ADC responder controls
    int adc_vec[9];
    int resp_idx    = 0;
    int resp_limit  = 0;
    bit spurious_en = 1'b0;

    // Max-register model (environment, not DUT)
    logic [11:0] m_lv = '0;
    logic [31:0] m_h  = 32'd500;
    logic [31:0] m_v  = 32'd500;
    assign bus.LV               = m_lv;
    assign bus.pulseWidth_max_H = m_h;
    assign bus.pulseWidth_max_V = m_v;

    always @(posedge clk) begin
        if (bus.MAX_CLR) begin
            m_lv <= '0;
            m_h  <= 32'd500;
            m_v  <= 32'd500;
        end else if (bus.CAPTURE) begin
            m_lv <= bus.ADC_DATA;
            m_h  <= bus.pulseWidth_H;
            m_v  <= bus.pulseWidth_V;
        end
    end

    task automatic check(input string name, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic int pos_now();
        return int'(bus.pulseWidth_H) * 10000 + int'(bus.pulseWidth_V);
    endfunction

    // Grid point p in raster order, H inner
    function automatic int pt(input int p);
        return (500 + 100 * (p % 3)) * 10000 + (500 + 100 * (p / 3));
    endfunction

    task automatic push_sweep(input logic [8:0] cap_mask, input int park);
        exp_clr++;
        for (int p = 0; p < 9; p++) begin
            exp_req.push_back(pt(p));
            if (cap_mask[p]) exp_cap.push_back(pt(p));
        end
        exp_done.push_back(park);
    endtask

    task automatic start_sweep();
        bus.START = 1'b1;
        @(negedge clk);
        bus.START = 1'b0;
        check("clear_busy", bus.BUSY, 1);
    endtask

    task automatic run_until_done(input int budget, input bit poke_start);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < budget && !seen; c++) begin
            if (poke_start && (c % 11 == 5)) bus.START = 1'b1;
            @(negedge clk);
            bus.START = 1'b0;
            if (bus.DONE) seen = 1'b1;
        end
        check("done_seen", seen, 1);
    endtask

    task automatic end_of_test(input string tag);
        @(negedge clk);
        check({tag, "_busy_after"}, bus.BUSY, 0);
        check({tag, "_done_1cyc"}, bus.DONE, 0);
        check({tag, "_req_left"}, exp_req.size(), 0);
        check({tag, "_cap_left"}, exp_cap.size(), 0);
        check({tag, "_done_left"}, exp_done.size(), 0);
        check({tag, "_clr_left"}, exp_clr, 0);
        repeat (5) @(negedge clk);
    endtask

    // Monitor: compare every DUT strobe against the scoreboard
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                if (bus.MAX_CLR) begin
                    check("clr_expected", exp_clr > 0, 1);
                    if (exp_clr > 0) exp_clr--;
                    check("clr_pos", pos_now(), pt(0));
                end
                if (bus.ADC_REQ) begin
                    check("req_expected", exp_req.size() > 0, 1);
                    if (exp_req.size() > 0) check("req_pos", pos_now(), exp_req.pop_front());
                end
                if (bus.CAPTURE) begin
                    check("cap_expected", exp_cap.size() > 0, 1);
                    if (exp_cap.size() > 0) check("cap_pos", pos_now(), exp_cap.pop_front());
                end
                if (bus.DONE) begin
                    check("done_expected", exp_done.size() > 0, 1);
                    if (exp_done.size() > 0) check("done_pos", pos_now(), exp_done.pop_front());
                    check("done_busy", bus.BUSY, 0);
                end
            end
        end
    end

    // ADC responder: answer each request two cycles later, optionally
    // followed by a stray valid with a huge sample during SETTLE
    initial begin : responder
        bus.ADC_VALID = 1'b0;
        bus.ADC_DATA  = '0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.ADC_REQ && resp_idx < resp_limit) begin
                repeat (2) @(negedge clk);
                bus.ADC_DATA  = 12'(adc_vec[resp_idx]);
                bus.ADC_VALID = 1'b1;
                resp_idx++;
                @(negedge clk);
                bus.ADC_VALID = 1'b0;
                if (spurious_en) begin
                    repeat (2) @(negedge clk);
                    bus.ADC_DATA  = 12'hFFF;
                    bus.ADC_VALID = 1'b1;
                    @(negedge clk);
                    bus.ADC_VALID = 1'b0;
                    bus.ADC_DATA  = 12'(adc_vec[resp_idx-1]);
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        bit seen;
        rst_n     = 1'b0;
        bus.START = 1'b0;
        bus.ABORT = 1'b0;
        #12;
        check("rst_pos", pos_now(), pt(0));
        check("rst_req", bus.ADC_REQ, 0);
        check("rst_cap", bus.CAPTURE, 0);
        check("rst_clr", bus.MAX_CLR, 0);
        check("rst_busy", bus.BUSY, 0);
        check("rst_done", bus.DONE, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // T1: increasing samples, every point captured
        adc_vec = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        resp_idx = 0; resp_limit = 9;
        push_sweep(9'h1FF, pt(8));
        start_sweep();
        run_until_done(400, 1'b0);
        end_of_test("t1");

        // T2: single peak at (600,700)
        adc_vec = '{100, 100, 100, 100, 100, 100, 100, 900, 100};
        resp_idx = 0; resp_limit = 9;
        push_sweep(9'b010000001, pt(7));
        start_sweep();
        run_until_done(400, 1'b0);
        end_of_test("t2");

        // T3: equal peaks, the later one is not captured
        adc_vec = '{800, 50, 50, 50, 50, 800, 50, 50, 50};
        resp_idx = 0; resp_limit = 9;
        push_sweep(9'b000000001, pt(0));
        start_sweep();
        run_until_done(400, 1'b0);
        end_of_test("t3");

        // T4: abort in the third SETTLE, at (700,500)
        adc_vec = '{10, 20, 30, 40, 50, 60, 70, 80, 90};
        resp_idx = 0; resp_limit = 9;
        exp_clr++;
        exp_req.push_back(pt(0)); exp_req.push_back(pt(1));
        exp_cap.push_back(pt(0)); exp_cap.push_back(pt(1));
        start_sweep();
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk);
            if (bus.pulseWidth_H == 32'd700) seen = 1'b1;
        end
        check("t4_reach_p2", seen, 1);
        bus.ABORT = 1'b1;
        @(negedge clk);
        bus.ABORT = 1'b0;
        check("t4_abort_busy", bus.BUSY, 0);
        check("t4_abort_pos", pos_now(), pt(2));
        check("t4_abort_done", bus.DONE, 0);
        repeat (12) @(negedge clk);
        check("t4_idle_pos", pos_now(), pt(2));
        check("t4_idle_busy", bus.BUSY, 0);
        end_of_test("t4");

        // T6: restart after abort, with START pokes while busy and stray
        // ADC_VALID pulses during SETTLE
        adc_vec = '{5, 3, 7, 7, 2, 9, 1, 9, 4};
        resp_idx = 0; resp_limit = 9;
        spurious_en = 1'b1;
        push_sweep(9'b000100101, pt(5));
        start_sweep();
        run_until_done(400, 1'b1);
        spurious_en = 1'b0;
        end_of_test("t6");

        // T5: asynchronous reset in the middle of WAIT at (600,500)
        adc_vec[0] = 50;
        resp_idx = 0; resp_limit = 1;
        exp_clr++;
        exp_req.push_back(pt(0)); exp_req.push_back(pt(1));
        exp_cap.push_back(pt(0));
        start_sweep();
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk);
            if (bus.ADC_REQ && pos_now() == pt(1)) seen = 1'b1;
        end
        check("t5_reach_req1", seen, 1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_pos", pos_now(), pt(0));
        check("t5_rst_req", bus.ADC_REQ, 0);
        check("t5_rst_cap", bus.CAPTURE, 0);
        check("t5_rst_clr", bus.MAX_CLR, 0);
        check("t5_rst_busy", bus.BUSY, 0);
        check("t5_rst_done", bus.DONE, 0);
        check("t5_req_left", exp_req.size(), 0);
        check("t5_cap_left", exp_cap.size(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("t5_idle_busy", bus.BUSY, 0);
        check("t5_idle_pos", pos_now(), pt(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
